// File: rtl/trdb_pkg.sv
// Shared types and constants for the trace debugger word buffer.
package trdb_pkg;

  localparam int XLEN = 32;
  localparam logic [15:0] TRDB_OVF_MARKER_TAG = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } trdb_wbuf_state_e;

endpackage

// File: rtl/trdb_fifo.sv
// Generic FIFO storage with one pop port and two write ports; the second
// write port lands one slot after the first and is only used with the first.
module trdb_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     push2,
  input  logic [WIDTH-1:0]         push2_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    wptr_p1;

  assign wptr_p1 = wptr + AW'(1);
  assign head    = mem[rptr];
  assign full    = (fill == FW'(DEPTH));
  assign empty   = (fill == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      fill <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push)  mem[wptr]    <= push_data;
      if (push2) mem[wptr_p1] <= push2_data;
      wptr <= wptr + AW'(push) + AW'(push2);
      if (pop) rptr <= rptr + AW'(1);
      fill <= fill + FW'(push) + FW'(push2) - FW'(pop);
    end
  end

endmodule

// File: rtl/trdb_word_buffer.sv
// Trace word buffer: FIFO plus burst/drain framing towards the uDMA.
// Optional TRDB_OVERFLOW_MARKER_EN inserts a {DEAD, drop count} word after drops.
module trdb_word_buffer
  import trdb_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int BURST_LEN    = 4,
  parameter int TIMEOUT      = 256,
  parameter int STALL_THRESH = DEPTH - 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [XLEN-1:0]        word_i,
  input  logic                   word_valid_i,
  output logic                   stall_o,
  input  logic                   flush_i,
  output logic [XLEN-1:0]        data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   last_o,
  output logic [$clog2(DEPTH):0] fill_o,
  output logic                   overflow_o,
  input  logic                   clear_overflow_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);

  trdb_wbuf_state_e state;
  logic [FW-1:0]    rem;
  logic [TW-1:0]    tmo_cnt;
  logic             flush_pending;
  logic [FW-1:0]    fill;
  logic             full, empty, pop, drop;
  logic             wr0, wr1;
  logic [XLEN-1:0]  wr0_data, wr1_data;

  trdb_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_fifo (
    .clk        (clk_i),
    .rst        (rst_i),
    .push       (wr0),
    .push_data  (wr0_data),
    .push2      (wr1),
    .push2_data (wr1_data),
    .pop        (pop),
    .head       (data_o),
    .fill       (fill),
    .full       (full),
    .empty      (empty)
  );

  assign fill_o  = fill;
  assign stall_o = (fill >= FW'(STALL_THRESH));
  assign valid_o = (state != IDLE) && !empty;
  assign last_o  = valid_o && (rem == FW'(1));
  assign pop     = valid_o && ready_i;

`ifdef TRDB_OVERFLOW_MARKER_EN
  logic [15:0]   drop_cnt;
  logic          marker_pending, marker_wr;
  logic [FW-1:0] free;

  assign free = FW'(DEPTH) - fill;

  // Free-slot checks use the registered fill; a same-cycle pop is not credited.
  always_comb begin
    wr0       = 1'b0;
    wr1       = 1'b0;
    drop      = 1'b0;
    marker_wr = 1'b0;
    wr0_data  = word_i;
    wr1_data  = word_i;
    if (marker_pending) begin
      wr0_data = XLEN'({TRDB_OVF_MARKER_TAG, drop_cnt});
      if (word_valid_i) begin
        if (free >= FW'(2)) begin
          wr0       = 1'b1;
          wr1       = 1'b1;
          marker_wr = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end else if (free != '0) begin
        wr0       = 1'b1;
        marker_wr = 1'b1;
      end
    end else if (word_valid_i) begin
      wr0  = !full;
      drop = full;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_overflow_i) begin
      drop_cnt       <= '0;
      marker_pending <= 1'b0;
    end else if (marker_wr) begin
      drop_cnt       <= '0;
      marker_pending <= 1'b0;
    end else if (drop) begin
      marker_pending <= 1'b1;
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  always_comb begin
    wr0      = word_valid_i && !full;
    wr1      = 1'b0;
    drop     = word_valid_i && full;
    wr0_data = word_i;
    wr1_data = word_i;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_o <= 1'b0;
    end else if (clear_overflow_i) begin
      overflow_o <= 1'b0;
    end else if (drop) begin
      overflow_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      rem           <= '0;
      tmo_cnt       <= '0;
      flush_pending <= 1'b0;
    end else begin
      if (flush_i) flush_pending <= 1'b1;
      case (state)
        IDLE: begin
          if (fill >= FW'(BURST_LEN)) begin
            state   <= BURST;
            rem     <= FW'(BURST_LEN);
            tmo_cnt <= '0;
          end else if ((flush_pending || tmo_cnt == TW'(TIMEOUT - 1)) && fill != '0) begin
            // Snapshot of fill: words arriving from now on wait for the next frame.
            state         <= DRAIN;
            rem           <= fill;
            tmo_cnt       <= '0;
            flush_pending <= 1'b0;
          end else begin
            if (fill == '0) flush_pending <= 1'b0;
            if (wr0 || fill == '0) tmo_cnt <= '0;
            else if (tmo_cnt != TW'(TIMEOUT - 1)) tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: begin
          tmo_cnt <= '0;
          if (pop) begin
            rem <= rem - FW'(1);
            if (rem == FW'(1)) state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trdb_word_buffer.sv
// Scoreboard bench for trdb_word_buffer (DEPTH=16, BURST_LEN=4, TIMEOUT=8).
module tb_trdb_word_buffer;
  import trdb_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [XLEN-1:0] word = '0;
  logic            word_valid = 1'b0;
  logic            stall, flush = 1'b0;
  logic [XLEN-1:0] data;
  logic            valid, ready = 1'b0, last;
  logic [4:0]      fill;
  logic            overflow, clear_overflow = 1'b0;

  int tests = 0;
  int fails = 0;
  logic [XLEN:0] expq [$];

  always #5 clk = ~clk;

  trdb_word_buffer #(.DEPTH(16), .BURST_LEN(4), .TIMEOUT(8), .STALL_THRESH(14)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .word_i           (word),
    .word_valid_i     (word_valid),
    .stall_o          (stall),
    .flush_i          (flush),
    .data_o           (data),
    .valid_o          (valid),
    .ready_i          (ready),
    .last_o           (last),
    .fill_o           (fill),
    .overflow_o       (overflow),
    .clear_overflow_i (clear_overflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [XLEN-1:0] w);
    word_valid = 1'b1;
    word = w;
    tick();
    word_valid = 1'b0;
  endtask

  task automatic wait_fill(input int target, input int budget, input string name);
    int c;
    for (c = 0; c < budget && fill != 5'(target); c++) tick();
    check(name, 64'(fill), 64'(target));
  endtask

  // Monitor: every accepted output beat is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      tests++;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_beat: got data %0h last %0b, expected no output", data, last);
      end else begin
        logic [XLEN:0] e;
        e = expq.pop_front();
        if ({last, data} !== e) begin
          fails++;
          $display("FAIL beat: got last %0b data %0h expected last %0b data %0h",
                   last, data, e[XLEN], e[XLEN-1:0]);
        end
      end
    end
  end

  initial begin
    tick(); tick();
    rst = 1'b0;
    check("reset_state", {valid, last, stall, overflow, fill, data},
          {1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0});

    // Regular burst
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expq.push_back({(i == 3), 32'h10 + 32'(i)});
      push(32'h10 + 32'(i));
    end
    check("burst_valid_before", 64'(valid), 64'd0);
    tick();
    check("burst_valid_rise", 64'(valid), 64'd1);
    wait_fill(0, 10, "burst_fill_empty");

    // Timeout drain
    expq.push_back({1'b0, 32'h20});
    expq.push_back({1'b1, 32'h21});
    push(32'h20);
    push(32'h21);
    for (int j = 1; j <= 7; j++) begin
      tick();
      check("tmo_quiet", 64'(valid), 64'd0);
    end
    tick();
    check("tmo_drain_start", 64'(valid), 64'd1);
    wait_fill(0, 6, "tmo_fill_empty");

    // Flush during a burst with toggling ready
    ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      expq.push_back({(i == 3 || i == 5), 32'h30 + 32'(i)});
      push(32'h30 + 32'(i));
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int c = 0; c < 16 && fill != 5'd0; c++) begin
      ready = (c % 2 == 0);
      tick();
    end
    check("flush_drain_done", 64'(fill), 64'd0);
    ready = 1'b0;

    // Overflow, stall threshold and sticky flag
    for (int i = 0; i < 20; i++) begin
      if (i < 16) expq.push_back({(i % 4 == 3), 32'h40 + 32'(i)});
      push(32'h40 + 32'(i));
      check("ovf_fill", 64'(fill), 64'((i < 16) ? i + 1 : 16));
      check("ovf_stall", 64'(stall), 64'(((i < 16) ? i + 1 : 16) >= 14));
      check("ovf_flag", 64'(overflow), 64'(i >= 16));
    end
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("ovf_cleared", 64'(overflow), 64'd0);
    ready = 1'b1;
    wait_fill(0, 60, "ovf_fill_empty");

`ifdef TRDB_OVERFLOW_MARKER_EN
    // Marker after 4 drops lands behind the stored words, ahead of 0xAB
    ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i < 16) expq.push_back({(i % 4 == 3), 32'h60 + 32'(i)});
      push(32'h60 + 32'(i));
    end
    ready = 1'b1;
    wait_fill(1, 60, "marker_alone");
    expq.push_back({1'b0, 32'hDEAD0004});
    expq.push_back({1'b1, 32'h000000AB});
    push(32'hAB);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_fill(0, 10, "marker_fill_empty");
`endif

    // Reset mid-burst discards the remaining words
    ready = 1'b0;
    expq.push_back({1'b0, 32'h80});
    for (int i = 0; i < 4; i++) push(32'h80 + 32'(i));
    tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_burst", {valid, last, overflow, fill}, {1'b0, 1'b0, 1'b0, 5'd0});
    ready = 1'b1;
    for (int j = 0; j < 12; j++) tick();
    check("rst_no_output", 64'(fill), 64'd0);
    check("scoreboard_empty", 64'(expq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
